fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
// PURPOSE
//  Sequences the instruction ROM: owns the PC, drives ROM chip-enable/address, captures the returned word.
//  Presents {pc, inst} to decode through a one-entry valid/ready output register.
//  Handles branch redirect, decode back-pressure, halt, and out-of-range/misaligned fetch faults.
//  Sits between the instruction ROM (combinational read) and the ID stage.
// PARAMETERS
//  ADDR_WIDTH  32   PC / ROM address width (byte address)
//  INST_WIDTH  32   instruction word width
//  RESET_PC    0    PC loaded on reset; must be word aligned
//  MEM_WORDS   10   ROM depth in words; valid fetch range is [0, MEM_WORDS*4)
// PORTS
//  clk           in   1           single clock, rising edge
//  rst           in   1           asynchronous, active-low reset
//  romCe         out  1           ROM chip enable (`ENABLE when fetching)
//  romAddr       out  ADDR_WIDTH  ROM byte address; always equals the PC register
//  romInst       in   INST_WIDTH  ROM read data, valid in the same cycle as romAddr
//  branchValid   in   1           one-cycle redirect request from EX
//  branchTarget  in   ADDR_WIDTH  redirect byte address
//  haltReq       in   1           stop fetching; sticky until reset
//  idValid       out  1           idPc/idInst hold a valid instruction
//  idReady       in   1           decode accepts this cycle (transfer = idValid & idReady)
//  idPc          out  ADDR_WIDTH  address of idInst
//  idInst        out  INST_WIDTH  fetched instruction
//  fetchFault    out  1           sticky: out-of-range PC or misaligned target seen
// BEHAVIOUR
//  Reset (async assert, sync release): state=OFF, pc=RESET_PC, romCe=0, idValid=0,
//   idPc=0, idInst=`ZERO_WORD, fetchFault=0.
//  States: OFF -> FETCH on the first edge after release (romCe rises that edge); no fetch while in OFF.
//   FETCH -> HALTED on haltReq or fault. HALTED is terminal until reset.
//  romCe = 1 only in FETCH. It is a registered output.
//  Output register is "free" when !idValid or idReady.
//  Fetch (FETCH, free, no branch, pc in range):
//   - capture on the edge: idInst<=romInst, idPc<=pc, idValid<=1, pc<=pc+4.
//   - gives one fetch per cycle and 1-cycle ROM-to-decode latency.
//  Stall (FETCH, idValid & !idReady): pc, idPc, idInst held; ROM output ignored.
//  Branch (branchValid in FETCH) has priority over stall and fetch:
//   - pc<=branchTarget; idValid<=0, dropping any held or in-flight word.
//   - the first target word is captured on the following edge.
//  Misaligned branch target (branchTarget[1:0]!=0):
//   - fetchFault<=1, state<=HALTED, idValid<=0, pc unchanged.
//  Out-of-range PC (pc >= MEM_WORDS*4) while in FETCH:
//   - no capture, fetchFault<=1, state<=HALTED.
//   - an already-valid output still drains normally.
//  Halt: haltReq in FETCH -> HALTED on that edge; no capture in that cycle.
//   - pending idValid drains on idReady and is never refilled.
//  Simultaneous branchValid & haltReq: pc<=target, idValid<=0, state<=HALTED.
//  In HALTED and OFF: branchValid and haltReq are ignored; romCe=0.
//  PC arithmetic: modulo 2^ADDR_WIDTH, carry discarded; wrap-around is caught by the range check.
//  Reset mid-operation: all registers return to reset values immediately (asynchronous).
// STRUCTURE
//  Shared define.v: `ENABLE/`DISABLE, `ZERO_WORD, `INST_ADDR_BUS, `INST_BUS,
//   and fetch state codes `FETCH_OFF/`FETCH_RUN/`FETCH_HALT (2-bit).
//  One natural sub-module: fetch_pc_reg (PC register, +4 adder, redirect mux, range/alignment check).
//  The top level holds the FSM and the output register.
// TESTING
//  1 Reset release, idReady=1, ROM words 0..3 = 0x11,0x22,0x33,0x44
//    -> romCe rises 1 edge after release; idInst 0x11,0x22,0x33 on consecutive cycles; idPc 0,4,8.
//  2 idReady=0 for 3 cycles while idValid, idInst=0x22
//    -> idPc/idInst stable at 4/0x22, romAddr held at 8; on idReady=1 the next word is 0x33 (no loss or duplicate).
//  3 branchValid, target=0x10, during a stall
//    -> next edge: idValid=0, romAddr=0x10; following edge: idPc=0x10 with word 4.
//  4 Run sequentially to MEM_WORDS=10
//    -> last captured idPc=0x24; fetchFault=1; state HALTED; romCe=0.
//  5 branchTarget=0x6 -> fetchFault=1, HALTED, idValid=0.
//    Separately, haltReq and branchValid in the same cycle -> HALTED, pc=target, idValid=0.
//  6 Assert rst mid-stall with idValid=1
//    -> idValid, romCe, fetchFault drop to 0 without a clock edge; fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/fetch_controller_pkg.sv
// Shared fetch-stage definitions: enable levels, instruction stride and FSM state codes.
package fetch_controller_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int unsigned INST_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH_OFF  = 2'b00,
    FETCH_RUN  = 2'b01,
    FETCH_HALT = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: sequential +4 advance, branch redirect, ROM range and target alignment checks.
module fetch_pc_reg
  import fetch_controller_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           MEM_WORDS  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  advance,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  in_range,
  output logic                  target_misaligned
);

  // One extra bit so a ROM that fills the whole address space still compares correctly.
  localparam logic [ADDR_WIDTH:0] PC_LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS * INST_BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target;
    end else if (advance) begin
      pc <= pc + ADDR_WIDTH'(INST_BYTES);
    end
  end

  assign in_range          = {1'b0, pc} < PC_LIMIT;
  assign target_misaligned = target[1:0] != 2'b00;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the FSM and the one-entry valid/ready register toward decode.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           MEM_WORDS  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  romCe,
  output logic [ADDR_WIDTH-1:0] romAddr,
  input  logic [INST_WIDTH-1:0] romInst,
  input  logic                  branchValid,
  input  logic [ADDR_WIDTH-1:0] branchTarget,
  input  logic                  haltReq,
  output logic                  idValid,
  input  logic                  idReady,
  output logic [ADDR_WIDTH-1:0] idPc,
  output logic [INST_WIDTH-1:0] idInst,
  output logic                  fetchFault
);

  fetch_state_e          state, state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  in_range, target_misaligned;
  logic                  advance, redirect, capture, flush, set_fault;
  logic                  out_free;

  fetch_pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC),
    .MEM_WORDS  (MEM_WORDS)
  ) u_pc_reg (
    .clk               (clk),
    .rst_n             (rst),
    .advance           (advance),
    .redirect          (redirect),
    .target            (branchTarget),
    .pc                (pc),
    .in_range          (in_range),
    .target_misaligned (target_misaligned)
  );

  assign romAddr  = pc;
  assign out_free = !idValid || idReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH_OFF;
    else      state <= state_next;
  end

  // Priority inside RUN: branch, then halt, then range fault, then capture if the output is free.
  always_comb begin
    state_next = state;
    advance    = 1'b0;
    redirect   = 1'b0;
    capture    = 1'b0;
    flush      = 1'b0;
    set_fault  = 1'b0;
    unique case (state)
      FETCH_OFF: state_next = FETCH_RUN;
      FETCH_RUN: begin
        if (branchValid) begin
          flush = 1'b1;
          if (target_misaligned) begin
            set_fault  = 1'b1;
            state_next = FETCH_HALT;
          end else begin
            redirect = 1'b1;
            if (haltReq) state_next = FETCH_HALT;
          end
        end else if (haltReq) begin
          state_next = FETCH_HALT;
        end else if (!in_range) begin
          set_fault  = 1'b1;
          state_next = FETCH_HALT;
        end else if (out_free) begin
          capture = 1'b1;
          advance = 1'b1;
        end
      end
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      romCe      <= DISABLE;
      idValid    <= 1'b0;
      idPc       <= '0;
      idInst     <= '0;
      fetchFault <= 1'b0;
    end else begin
      romCe <= (state_next == FETCH_RUN) ? ENABLE : DISABLE;
      if (set_fault) fetchFault <= 1'b1;
      if (capture) begin
        idValid <= 1'b1;
        idPc    <= pc;
        idInst  <= romInst;
      end else if (flush || idReady) begin
        idValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a ROM model and an expected-transfer scoreboard.
module tb_fetch_controller;

  logic        clk;
  logic        rst;
  logic        romCe;
  logic [31:0] romAddr;
  logic [31:0] romInst;
  logic        branchValid;
  logic [31:0] branchTarget;
  logic        haltReq;
  logic        idValid;
  logic        idReady;
  logic [31:0] idPc;
  logic [31:0] idInst;
  logic        fetchFault;

  int n_tests = 0;
  int n_fails = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];

  fetch_controller #(
    .ADDR_WIDTH (32),
    .INST_WIDTH (32),
    .RESET_PC   (32'h0),
    .MEM_WORDS  (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .romCe        (romCe),
    .romAddr      (romAddr),
    .romInst      (romInst),
    .branchValid  (branchValid),
    .branchTarget (branchTarget),
    .haltReq      (haltReq),
    .idValid      (idValid),
    .idReady      (idReady),
    .idPc         (idPc),
    .idInst       (idInst),
    .fetchFault   (fetchFault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word k holds (k+1)*0x11, so words 0..3 are 0x11,0x22,0x33,0x44.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  assign romInst = (romAddr < 32'd40) ? rom_word(romAddr) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_q.push_back('{pc: a, inst: rom_word(a)});
  endtask

  // Transfers are scored on the value presented before the edge, then time moves to 1ns past it.
  task automatic tick();
    exp_t e;
    if (idValid && idReady) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fails++;
        $error("FAIL xfer_unexpected observed=%0h expected=none", idPc);
      end else begin
        e = exp_q.pop_front();
        check("xfer_pc", idPc, e.pc);
        check("xfer_inst", idInst, e.inst);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("rst_valid", idValid, 1'b0);
    check("rst_ce", romCe, 1'b0);
    check("rst_fault", fetchFault, 1'b0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst          = 1'b0;
    idReady      = 1'b1;
    branchValid  = 1'b0;
    branchTarget = '0;
    haltReq      = 1'b0;
    tick();
    tick();

    // 1: reset state, startup, back-to-back fetch
    check("reset_ce", romCe, 1'b0);
    check("reset_valid", idValid, 1'b0);
    check("reset_pc", idPc, 32'h0);
    check("reset_inst", idInst, 32'h0);
    check("reset_addr", romAddr, 32'h0);
    check("reset_fault", fetchFault, 1'b0);
    rst = 1'b1;
    push(32'h0); push(32'h4);
    tick();
    check("t1_ce_rise", romCe, 1'b1);
    check("t1_valid_e1", idValid, 1'b0);
    tick();
    check("t1_inst0", idInst, 32'h11);
    check("t1_pc0", idPc, 32'h0);
    tick();
    check("t1_inst1", idInst, 32'h22);
    tick();
    check("t1_inst2", idInst, 32'h33);
    check("t1_pc2", idPc, 32'h8);

    // 2: stall holding 0x22
    do_reset();
    push(32'h0); push(32'h4);
    tick(); tick(); tick();
    idReady = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("t2_hold_pc", idPc, 32'h4);
      check("t2_hold_inst", idInst, 32'h22);
      check("t2_hold_addr", romAddr, 32'h8);
      check("t2_hold_valid", idValid, 1'b1);
    end
    idReady = 1'b1;
    tick();
    check("t2_next_inst", idInst, 32'h33);
    check("t2_next_pc", idPc, 32'h8);

    // 3: branch during a stall drops the held word
    idReady = 1'b0;
    tick();
    branchValid  = 1'b1;
    branchTarget = 32'h10;
    tick();
    branchValid = 1'b0;
    check("t3_flush_valid", idValid, 1'b0);
    check("t3_addr", romAddr, 32'h10);
    idReady = 1'b1;
    push(32'h10);
    tick();
    check("t3_tgt_pc", idPc, 32'h10);
    check("t3_tgt_inst", idInst, 32'h55);

    // 4: run off the end of the ROM
    for (int unsigned a = 32'h14; a <= 32'h24; a += 4) push(32'(a));
    repeat (5) tick();
    check("t4_last_pc", idPc, 32'h24);
    check("t4_addr_end", romAddr, 32'h28);
    check("t4_no_fault_yet", fetchFault, 1'b0);
    tick();
    check("t4_fault", fetchFault, 1'b1);
    check("t4_ce_off", romCe, 1'b0);
    check("t4_drained", idValid, 1'b0);
    branchValid  = 1'b1;
    branchTarget = 32'h0;
    tick();
    branchValid = 1'b0;
    tick();
    check("t4_halt_addr", romAddr, 32'h28);
    check("t4_halt_ce", romCe, 1'b0);
    check("t4_halt_valid", idValid, 1'b0);
    check("t4_q_empty", 32'(exp_q.size()), 32'h0);

    // 5a: misaligned branch target
    do_reset();
    tick(); tick();
    idReady      = 1'b0;
    branchValid  = 1'b1;
    branchTarget = 32'h6;
    tick();
    branchValid = 1'b0;
    check("t5a_fault", fetchFault, 1'b1);
    check("t5a_valid", idValid, 1'b0);
    check("t5a_ce", romCe, 1'b0);
    check("t5a_pc_held", romAddr, 32'h4);

    // 5b: branch and halt together
    do_reset();
    tick(); tick();
    branchValid  = 1'b1;
    haltReq      = 1'b1;
    branchTarget = 32'h20;
    tick();
    branchValid = 1'b0;
    haltReq     = 1'b0;
    tick();
    check("t5b_addr", romAddr, 32'h20);
    check("t5b_valid", idValid, 1'b0);
    check("t5b_ce", romCe, 1'b0);
    check("t5b_fault", fetchFault, 1'b0);

    // 5c: halt with a pending word; it drains once and is never refilled
    idReady = 1'b1;
    do_reset();
    tick(); tick();
    idReady = 1'b0;
    haltReq = 1'b1;
    tick();
    haltReq = 1'b0;
    check("t5c_pending", idValid, 1'b1);
    check("t5c_ce", romCe, 1'b0);
    idReady = 1'b1;
    push(32'h0);
    tick();
    tick();
    check("t5c_drained", idValid, 1'b0);
    check("t5c_addr", romAddr, 32'h4);

    // 6: asynchronous reset mid-stall
    do_reset();
    tick(); tick();
    idReady = 1'b0;
    tick();
    check("t6_stall_valid", idValid, 1'b1);
    rst = 1'b0;
    #2;
    check("t6_async_valid", idValid, 1'b0);
    check("t6_async_ce", romCe, 1'b0);
    check("t6_async_fault", fetchFault, 1'b0);
    check("t6_async_addr", romAddr, 32'h0);
    tick(); tick();
    rst     = 1'b1;
    idReady = 1'b1;
    push(32'h0); push(32'h4);
    tick(); tick();
    check("t6_restart_pc", idPc, 32'h0);
    check("t6_restart_inst", idInst, 32'h11);
    tick(); tick();
    check("t6_q_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
